// File: rtl/tt_um_uart_transmitter_pkg.sv
// Shared constants for the Hamming(7,4) UART link: FSM encoding, oversampling
// default and codeword bit positions (common to transmitter, receiver and decoder).
package tt_um_uart_transmitter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_DATA  = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS      = 7;

  // Codeword layout c[6:0] = {d4,d3,d2,p3,d1,p2,p1}
  localparam int CW_P1 = 0;
  localparam int CW_P2 = 1;
  localparam int CW_D1 = 2;
  localparam int CW_P3 = 3;
  localparam int CW_D2 = 4;
  localparam int CW_D3 = 5;
  localparam int CW_D4 = 6;

endpackage

// File: rtl/tt_um_uart_transmitter_hamming74_encoder.sv
// Combinational Hamming(7,4) encoder: nibble d1..d4 = data_i[0..3] to 7-bit codeword.
module hamming74_encoder
  import tt_um_uart_transmitter_pkg::*;
(
  input  logic [3:0]           data_i,
  output logic [DATA_BITS-1:0] code_o
);

  logic d1, d2, d3, d4;

  assign d1 = data_i[0];
  assign d2 = data_i[1];
  assign d3 = data_i[2];
  assign d4 = data_i[3];

  always_comb begin
    code_o        = '0;
    code_o[CW_P1] = d1 ^ d2 ^ d4;
    code_o[CW_P2] = d1 ^ d3 ^ d4;
    code_o[CW_D1] = d1;
    code_o[CW_P3] = d2 ^ d3 ^ d4;
    code_o[CW_D2] = d2;
    code_o[CW_D3] = d3;
    code_o[CW_D4] = d4;
  end

endmodule

// File: rtl/tt_um_uart_transmitter.sv
// UART transmitter for Hamming(7,4) codewords: start, 7 bits LSB-first, stop,
// each bit held OVERSAMPLE ena-qualified ticks; tx is registered.
module tt_um_uart_transmitter
  import tt_um_uart_transmitter_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic [1:0] state_out,
  output logic       frame_done
);

  localparam int                CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        BIT_LAST = 3'(DATA_BITS - 1);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     sample_cnt_q, sample_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] code_q, code_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] enc_code;
  logic                 tick_last;
  logic                 accept;

  hamming74_encoder u_enc (
    .data_i (data_in),
    .code_o (enc_code)
  );

  assign tick_last  = (sample_cnt_q == CNT_LAST);
  assign data_ready = (state_q == ST_IDLE) | ((state_q == ST_STOP) & tick_last);
  assign accept     = ena & data_valid & data_ready;
  assign frame_done = ena & (state_q == ST_STOP) & tick_last;

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    code_d       = code_q;
    tx_d         = tx_q;
    if (ena) begin
      sample_cnt_d = sample_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          sample_cnt_d = '0;
          tx_d         = 1'b1;
        end
        ST_START: begin
          if (tick_last) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            tx_d      = code_q[0];
          end
        end
        ST_DATA: begin
          if (tick_last) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              tx_d      = code_q[bit_cnt_d];
            end
          end
        end
        ST_STOP: begin
          if (tick_last) begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          tx_d         = 1'b1;
        end
      endcase
      // Accept overrides the STOP->IDLE exit so back-to-back frames have no gap
      if (accept) begin
        state_d      = ST_START;
        sample_cnt_d = '0;
        bit_cnt_d    = '0;
        code_d       = enc_code;
        tx_d         = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      code_q       <= '0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      code_q       <= code_d;
      tx_q         <= tx_d;
    end
  end

  assign tx        = tx_q;
  assign state_out = state_q;

endmodule
